// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int unsigned MEM_BYTES_DEFAULT  = 1024;
    localparam int unsigned STARVE_MAX_DEFAULT = 3;

    // Word accesses must be aligned and fit entirely inside the memory.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between IF and DM with an IF starvation counter.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       arb_en_i,
    input  logic       if_req_i,
    input  logic       dm_req_i,
    input  logic [1:0] mask_i,
    output owner_e     winner_o,
    output logic       valid_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       if_cand, dm_cand;

    // mask_i[0] hides IF, mask_i[1] hides DM (the owner being answered in RESP).
    always_comb begin
        if_cand  = if_req_i & ~mask_i[0];
        dm_cand  = dm_req_i & ~mask_i[1];
        valid_o  = if_cand | dm_cand;
        winner_o = (dm_cand && !(if_cand && (starve_q >= STARVE_LIM))) ? OWN_DM : OWN_IF;
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_i) begin
            starve_d = '0;
        end else if (arb_en_i && valid_o) begin
            if (winner_o == OWN_IF) begin
                starve_d = '0;
            end else if (if_cand && (starve_q < STARVE_LIM)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM-stage arbiter for the single unified memory port (access cycle + response cycle).
// Optional grant/stall statistics counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        addr_err,
    output logic [15:0] stat_if_grants,
    output logic [15:0] stat_dm_grants,
    output logic [15:0] stat_if_stall
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      win;
    logic        win_valid;
    logic        arb_en;
    logic [1:0]  arb_mask;
    logic [31:0] acc_addr;
    logic        acc_legal, acc_store;
    logic [31:0] if_rdata_q, dm_rdata_q;
    logic        if_ready_q, dm_ready_q, err_q;

    assign arb_en = (state_q == IDLE) || (state_q == RESP);

    always_comb begin
        arb_mask = 2'b00;
        if (state_q == RESP) begin
            arb_mask = (owner_q == OWN_IF) ? 2'b01 : 2'b10;
        end
    end

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .arb_en_i (arb_en),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .mask_i   (arb_mask),
        .winner_o (win),
        .valid_o  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (win_valid) begin
                    state_d = ACCESS;
                    owner_d = win;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_addr  = (owner_q == OWN_DM) ? dm_addr : if_addr;
        acc_legal = addr_legal(acc_addr, MEM_BYTES);
        acc_store = (owner_q == OWN_DM) && dm_we;
    end

    // Strobes are gated by rst_n so a reset landing mid-ACCESS commits nothing.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        if (state_q == ACCESS) begin
            mem_addr  = acc_addr;
            mem_wd    = dm_wdata;
            mem_read  = rst_n && acc_legal && !acc_store;
            mem_write = rst_n && acc_legal && acc_store;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == ACCESS) begin
                err_q <= !acc_legal;
                if (owner_q == OWN_IF) begin
                    if_ready_q <= 1'b1;
                    if_rdata_q <= acc_legal ? mem_rd : '0;
                end else begin
                    dm_ready_q <= 1'b1;
                    dm_rdata_q <= (acc_legal && !acc_store) ? mem_rd : '0;
                end
            end
        end
    end

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ready = if_ready_q;
    assign dm_ready = dm_ready_q;
    assign addr_err = err_q;

`ifdef ARB_STATS_EN
    logic [15:0] if_grants_q, dm_grants_q, if_stall_q;
    logic        grant;

    assign grant = arb_en && win_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_grants_q <= '0;
            dm_grants_q <= '0;
            if_stall_q  <= '0;
        end else begin
            if (grant && (win == OWN_IF) && (if_grants_q != '1)) if_grants_q <= if_grants_q + 16'd1;
            if (grant && (win == OWN_DM) && (dm_grants_q != '1)) dm_grants_q <= dm_grants_q + 16'd1;
            if (if_req && !if_ready_q && (if_stall_q != '1)) if_stall_q <= if_stall_q + 16'd1;
        end
    end

    assign stat_if_grants = if_grants_q;
    assign stat_dm_grants = dm_grants_q;
    assign stat_if_stall  = if_stall_q;
`else
    assign stat_if_grants = '0;
    assign stat_dm_grants = '0;
    assign stat_if_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-timeline reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MB = 1024;
    localparam int unsigned SM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wd, mem_rd;
    logic        if_ready, dm_ready, mem_read, mem_write, addr_err;
    logic [15:0] stat_if_grants, stat_dm_grants, stat_if_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_BYTES(MB), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .addr_err(addr_err),
        .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants), .stat_if_stall(stat_if_stall)
    );

    // Environment memory: combinational little-endian read, write on posedge.
    logic [7:0] mem     [0:MB-1];
    logic [7:0] ref_mem [0:MB-1];
    logic [9:0] ma;
    assign ma     = mem_addr[9:0];
    assign mem_rd = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma]          <= mem_wd[7:0];
            mem[ma + 10'd1]  <= mem_wd[15:8];
            mem[ma + 10'd2]  <= mem_wd[23:16];
            mem[ma + 10'd3]  <= mem_wd[31:24];
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    txn_t if_q[$];
    txn_t dm_q[$];
    logic if_cool, dm_cool, rnd_on;

    int unsigned errors = 0, checks = 0;
    int unsigned k = 0;

    // Reference model: at most one grant in flight; ACCESS at g_c+1, ready at g_c+2.
    logic        g_valid, g_legal, g_we;
    owner_e      g_owner;
    int unsigned g_c, free_at, starve;
    logic [31:0] g_addr, g_wdata, g_rdata;
    int unsigned m_ifg, m_dmg, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.addr = addr; t.wd = wd;
        return t;
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= MB - 4);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int unsigned i = int'(a[9:0]);
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    function automatic txn_t rand_txn(input logic is_dm);
        txn_t t;
        int unsigned sel = $urandom_range(0, 7);
        t.we = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
        t.wd = $urandom();
        if (sel == 0)      t.addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (sel == 1) t.addr = MB + 4 * $urandom_range(0, 15);
        else               t.addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        return t;
    endfunction

    function automatic logic quiet();
        return (if_q.size() == 0) && (dm_q.size() == 0) && !if_req && !dm_req &&
               !if_cool && !dm_cool && !(g_valid && (k < g_c + 2));
    endfunction

    task automatic model_reset();
        g_valid = 1'b0; free_at = k + 1; starve = 0;
        m_ifg = 0; m_dmg = 0; m_stall = 0;
        if_cool = 1'b0; dm_cool = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef ARB_STATS_EN
        chk("stat_if_grants", 32'(stat_if_grants), m_ifg);
        chk("stat_dm_grants", 32'(stat_dm_grants), m_dmg);
        chk("stat_if_stall",  32'(stat_if_stall),  m_stall);
`else
        chk("stats_tied_zero", {stat_if_grants, stat_dm_grants} | 32'(stat_if_stall), 32'h0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {30'h0, if_ready, dm_ready}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
        chk({tag, "_strobes"}, {29'h0, mem_read, mem_write, addr_err}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr | mem_wd, 32'h0);
    endtask

    task automatic cycle();
        logic   e_acc, e_rdy, e_ifr, e_dmr, e_rd, e_wr, ci, cd;
        owner_e w;
        txn_t   t;
        int unsigned ns;
        @(negedge clk);
        k++;
        e_acc = g_valid && (k == g_c + 1);
        e_rdy = g_valid && (k == g_c + 2);
        e_ifr = e_rdy && (g_owner == OWN_IF);
        e_dmr = e_rdy && (g_owner == OWN_DM);
        e_rd  = e_acc && g_legal && !g_we;
        e_wr  = e_acc && g_legal && g_we;
        chk("if_ready", 32'(if_ready), 32'(e_ifr));
        chk("dm_ready", 32'(dm_ready), 32'(e_dmr));
        chk("mem_read", 32'(mem_read), 32'(e_rd));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("mem_addr", mem_addr, e_acc ? g_addr : 32'h0);
        if (e_wr) begin
            chk("mem_wd", mem_wd, g_wdata);
            ref_mem[g_addr[9:0]]         = g_wdata[7:0];
            ref_mem[g_addr[9:0] + 10'd1] = g_wdata[15:8];
            ref_mem[g_addr[9:0] + 10'd2] = g_wdata[23:16];
            ref_mem[g_addr[9:0] + 10'd3] = g_wdata[31:24];
        end
        if (e_ifr) chk("if_rdata", if_rdata, g_rdata);
        if (e_dmr) chk("dm_rdata", dm_rdata, g_rdata);
        chk("addr_err", 32'(addr_err), 32'(e_rdy && !g_legal));
        chk_stats();

        // Requesters: hold until ready, stay low one extra cycle, then take next job.
        if (if_ready) begin
            if_req = 1'b0; if_cool = 1'b1;
        end else if (if_cool) begin
            if_cool = 1'b0;
        end else if (!if_req) begin
            if (rnd_on && if_q.size() == 0 && $urandom_range(0, 2) == 0) if_q.push_back(rand_txn(1'b0));
            if (if_q.size() > 0) begin
                t = if_q.pop_front(); if_addr = t.addr; if_req = 1'b1;
            end
        end
        if (dm_ready) begin
            dm_req = 1'b0; dm_cool = 1'b1;
        end else if (dm_cool) begin
            dm_cool = 1'b0;
        end else if (!dm_req) begin
            if (rnd_on && dm_q.size() == 0 && $urandom_range(0, 2) == 0) dm_q.push_back(rand_txn(1'b1));
            if (dm_q.size() > 0) begin
                t = dm_q.pop_front(); dm_addr = t.addr; dm_we = t.we; dm_wdata = t.wd; dm_req = 1'b1;
            end
        end

        // Arbitration decided at the coming posedge.
        if (if_req && !e_ifr && m_stall < 65535) m_stall++;
        ns = starve;
        if (k >= free_at) begin
            ci = if_req && !e_ifr;
            cd = dm_req && !e_dmr;
            if (ci || cd) begin
                w = (cd && !(ci && starve >= SM)) ? OWN_DM : OWN_IF;
                if (w == OWN_IF) begin
                    ns = 0;
                    if (m_ifg < 65535) m_ifg++;
                end else begin
                    if (ci && starve < SM) ns = starve + 1;
                    if (m_dmg < 65535) m_dmg++;
                end
                g_valid = 1'b1; g_owner = w; g_c = k;
                g_addr  = (w == OWN_IF) ? if_addr : dm_addr;
                g_we    = (w == OWN_DM) && dm_we;
                g_wdata = dm_wdata;
                g_legal = legal(g_addr);
                g_rdata = (g_legal && !g_we) ? ref_word(g_addr) : 32'h0;
                free_at = k + 2;
            end else begin
                free_at = k + 1;
            end
        end
        if (!if_req) ns = 0;
        starve = ns;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (n < budget && !quiet()) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(quiet()), 32'h1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); k++;
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk); k++;
        chk_all_zero(tag);
        chk({tag, "_stats"}, {stat_if_grants, stat_dm_grants} | 32'(stat_if_stall), 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int unsigned n, bad;
        rnd_on = 1'b0;
        for (int i = 0; i < MB; i++) begin
            mem[i] = 8'($urandom()); ref_mem[i] = mem[i];
        end
        mem[16'h10] = 8'h8C; mem[16'h11] = 8'h01; mem[16'h12] = 8'h00; mem[16'h13] = 8'h20;
        for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = mem[i];

        do_reset("reset");

        // IF-only fetch
        if_q.push_back(mk(1'b0, 32'h10, 32'h0));
        drain(40);
        chk("fetch_word", if_rdata, 32'h2000018C);

        // DM store then load of the same word
        dm_q.push_back(mk(1'b1, 32'h40, 32'hDEADBEEF));
        dm_q.push_back(mk(1'b0, 32'h40, 32'h0));
        drain(60);
        chk("load_back", dm_rdata, 32'hDEADBEEF);

        // Contention between both requesters
        for (int i = 0; i < 5; i++) begin
            if_q.push_back(mk(1'b0, 32'(4 * i), 32'h0));
            dm_q.push_back(mk(i[0], 32'(16'h100 + 4 * i), $urandom()));
        end
        drain(200);

        // Illegal addresses: unaligned and past the end
        dm_q.push_back(mk(1'b0, 32'h3FE, 32'h0));
        dm_q.push_back(mk(1'b0, 32'h400, 32'h0));
        dm_q.push_back(mk(1'b1, 32'h3FE, 32'h12345678));
        drain(80);
        chk("illegal_rdata", dm_rdata, 32'h0);

        // Reset landing in the ACCESS cycle of a store
        dm_q.push_back(mk(1'b1, 32'h80, 32'hCAFEF00D));
        n = 0;
        while (n < 40 && !(g_valid && g_c == k && g_owner == OWN_DM)) begin
            cycle(); n++;
        end
        chk("store_granted", 32'(g_valid && g_c == k), 32'h1);
        @(negedge clk); k++;
        chk("pre_reset_write", 32'(mem_write), 32'h1);
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        #1;
        chk("reset_gates_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk); k++;
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        dm_q.delete();
        model_reset();
        chk("mem80_kept", {mem[16'h83], mem[16'h82], mem[16'h81], mem[16'h80]}, ref_word(32'h80));
        if_q.push_back(mk(1'b0, 32'h80, 32'h0));
        dm_q.push_back(mk(1'b0, 32'h10, 32'h0));
        drain(60);
        chk("post_reset_fetch", if_rdata, ref_word(32'h80));

        // Statistics: 5 IF and 3 DM grants from a clean reset
        do_reset("stats_reset");
        for (int i = 0; i < 5; i++) if_q.push_back(mk(1'b0, 32'(8 * i), 32'h0));
        for (int i = 0; i < 3; i++) dm_q.push_back(mk(1'b0, 32'(16'h200 + 4 * i), 32'h0));
        drain(200);
`ifdef ARB_STATS_EN
        chk("stat_if_total", 32'(stat_if_grants), 32'd5);
        chk("stat_dm_total", 32'(stat_dm_grants), 32'd3);
`else
        chk("stat_if_total", 32'(stat_if_grants), 32'd0);
        chk("stat_dm_total", 32'(stat_dm_grants), 32'd0);
`endif

        // Random traffic
        rnd_on = 1'b1;
        for (int i = 0; i < 600; i++) cycle();
        rnd_on = 1'b0;
        drain(100);

        bad = 0;
        for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
